mux2x1_arbiter: RTL and testbench
=================================

# mux2x1_arbiter

Round-robin arbiter that shares one 2:1 data mux between two streaming sources and one sink. It holds a grant for a bounded burst, drives the mux select, and registers the selected beat into a one-entry output stage with a valid/ready handshake. It sits in front of any shared consumer that two producers must reach through a single 2:1 select path.

## Interface
Parameters:
- WIDTH, 8, data width of each source and of the output.
- MAX_BURST, 4, maximum beats per grant; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- s0_valid  input  1  source 0 has a beat.
- s0_data  input  WIDTH  source 0 beat.
- s0_ready  output  1  source 0 beat accepted this cycle when high with s0_valid.
- s1_valid / s1_data / s1_ready  same, for source 1.
- m_valid  output  1  output register holds a beat.
- m_data  output  WIDTH  registered beat.
- m_src  output  1  source index of the beat in m_data.
- m_ready  input  1  sink accepts m_data when high with m_valid.
- gnt  output  2  one-hot current grant (gnt[0] = source 0); 00 when idle.

## Operation
- Datapath: the per-bit 2:1 mux (i0 = s0_data, i1 = s1_data) uses select sel = (state == GRANT1).
- Slot free: free = !m_valid || m_ready.
- Ready: sX_ready = (state == GRANTX) && free. It is combinational from state, m_valid and m_ready. It is never asserted in IDLE.
- Beat accept: acc = sX_valid && sX_ready. On acc, the registers load m_data ← mux output, m_src ← X, m_valid ← 1.
- Output drain: when m_ready && m_valid and there is no acc, m_valid ← 0.
- Priority register prio (1 bit) names the favoured source. It resets to 0.
- Burst counter cnt: width clog2(MAX_BURST)+1. It clears on every grant entry and increments on each acc.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE transitions:
  - Both valid: go to GRANT{prio}.
  - One valid: go to that source.
  - Neither valid: stay in IDLE.
- GRANTX release conditions: (a) acc with cnt == MAX_BURST-1, or (b) sX_valid low. On release, prio ← other source.
- Release target:
  - Other source valid: go directly to GRANT{other}.
  - Otherwise, sX still valid after condition (a): stay in GRANTX with cnt cleared. This is a new burst.
  - Otherwise: go to IDLE.
- Sources must hold valid and data stable until accepted. If valid drops, the grant is released in that same cycle and no beat is taken.

## Timing
- Reset values: m_valid 0, m_data 0, m_src 0, gnt 00, s0_ready 0, s1_ready 0, state IDLE, prio 0, cnt 0.
- Latency from IDLE:
  - Valid seen in cycle N.
  - Grant in cycle N+1, with ready high if the slot is free.
  - m_valid high in cycle N+2.
- Continuous streaming: with m_ready held high, the block sustains 1 beat/cycle within a burst.
- Grant handover: switches with no idle cycle when the other source is waiting.
- Backpressure: with m_ready low and m_valid high, ready stays low, the grant holds, and cnt is frozen. The burst is not released by stall alone.
- Simultaneous fill and drain: acc in the same cycle as m_ready accepting the old beat loads the new beat, and m_valid stays 1.
- MAX_BURST = 1: ownership alternates on every beat whenever both sources are valid.
- Reset mid-operation: the in-flight m_data beat is discarded and all state returns to reset values on the next edge. A source beat presented in the reset cycle is not accepted.

## Test plan
- Reset, then s0_valid=1 with data 0xA1 and m_ready=1:
  - gnt=01 at N+1 with s0_ready=1.
  - m_valid=1, m_data=0xA1, m_src=0 at N+2.
  - m_valid=0 one cycle later, once s0 drops.
- Both sources continuously valid, MAX_BURST=4, m_ready=1:
  - Output m_src sequence is 0,0,0,0,1,1,1,1,0,…
  - No bubble at handover.
- Both valid, m_ready low for 5 cycles mid-burst:
  - m_data holds and both readies are 0.
  - gnt is unchanged.
  - After release, the burst completes its remaining beats.
- s0 streaming; s0_valid drops after 2 beats while s1 is valid:
  - gnt goes to 10 in the cycle after the drop.
  - Next prio favours s1.
- MAX_BURST=1, both valid: m_src alternates 0,1,0,1 at 1 beat/cycle.
- Assert rst during a burst with m_valid=1:
  - Next cycle: m_valid=0, gnt=00, prio=0, s0_ready=s1_ready=0.
  - Arbitration restarts from IDLE.

Source files
------------

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two streaming sources,
// with bounded bursts and a one-entry registered output stage.
module mux2x1_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_valid,
   input  logic [WIDTH-1:0] s0_data,
   output logic             s0_ready,
   input  logic             s1_valid,
   input  logic [WIDTH-1:0] s1_data,
   output logic             s1_ready,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   output logic             m_src,
   input  logic             m_ready,
   output logic [1:0]       gnt,
   output logic [1:0]       dbg_state,
   output logic             dbg_prio
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t        state, state_n;
   logic          prio, prio_n;
   logic [CW-1:0] cnt, cnt_n;

   logic             sel;
   logic             granted;
   logic             free;
   logic             own_valid;
   logic             other_valid;
   logic             acc;
   logic             last;
   logic             rel;
   logic [WIDTH-1:0] mux_out;

   // Handshake: a beat moves on any edge where valid && ready; ready never
   // depends on the same-side valid, and the output slot is free when empty
   // or being drained by the sink in the same cycle.
   assign sel         = (state == GRANT1);
   assign granted     = (state == GRANT0) || (state == GRANT1);
   assign free        = !m_valid || m_ready;
   assign own_valid   = sel ? s1_valid : s0_valid;
   assign other_valid = sel ? s0_valid : s1_valid;
   assign acc         = granted && own_valid && free;
   assign last        = acc && (cnt == CW'(MAX_BURST - 1));
   assign rel         = granted && (last || !own_valid);
   assign mux_out     = sel ? s1_data : s0_data;

   assign s0_ready  = (state == GRANT0) && free;
   assign s1_ready  = (state == GRANT1) && free;
   assign gnt       = {state == GRANT1, state == GRANT0};
   assign dbg_state = state;
   assign dbg_prio  = prio;

   always_comb begin
      state_n = state;
      prio_n  = prio;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (s0_valid && s1_valid) state_n = prio ? GRANT1 : GRANT0;
            else if (s0_valid)        state_n = GRANT0;
            else if (s1_valid)        state_n = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (rel) begin
               // Hand over if the other side waits; otherwise a still-valid
               // owner starts a fresh burst.
               prio_n = ~sel;
               cnt_n  = '0;
               if (other_valid)    state_n = sel ? GRANT0 : GRANT1;
               else if (own_valid) state_n = state;
               else                state_n = IDLE;
            end else if (acc) begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         prio  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         prio  <= prio_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_src   <= 1'b0;
      end else if (acc) begin
         m_valid <= 1'b1;
         m_data  <= mux_out;
         m_src   <= sel;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Directed bench for mux2x1_arbiter: one instance with MAX_BURST=4 and one
// with MAX_BURST=1 share the same stimulus.
module tb_mux2x1_arbiter;

   logic       clk;
   logic       rst;
   logic       s0_valid, s1_valid, m_ready;
   logic [7:0] s0_data, s1_data;

   logic       s0_ready_4, s1_ready_4, m_valid_4, m_src_4, prio_4;
   logic [7:0] m_data_4;
   logic [1:0] gnt_4, state_4;
   logic       s0_ready_1, s1_ready_1, m_valid_1, m_src_1, prio_1;
   logic [7:0] m_data_1;
   logic [1:0] gnt_1, state_1;

   int n_total;
   int n_bad;
   logic [31:0] exp_q[$];

   mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready_4),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready_4),
      .m_valid(m_valid_4), .m_data(m_data_4), .m_src(m_src_4),
      .m_ready(m_ready), .gnt(gnt_4), .dbg_state(state_4), .dbg_prio(prio_4)
   );

   mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready_1),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready_1),
      .m_valid(m_valid_1), .m_data(m_data_1), .m_src(m_src_1),
      .m_ready(m_ready), .gnt(gnt_1), .dbg_state(state_1), .dbg_prio(prio_1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      s0_data  = 8'h00;
      s1_data  = 8'h00;
      m_ready  = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic drive_both(input logic [7:0] d0, input logic [7:0] d1);
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data  = d0;
      s1_data  = d1;
      m_ready  = 1'b1;
   endtask

   initial begin
      logic [31:0] e;
      n_total = 0;
      n_bad   = 0;

      // reset values
      do_reset();
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid_4), 32'd0);
      chk("rst_m_data", 32'(m_data_4), 32'h00);
      chk("rst_m_src", 32'(m_src_4), 32'd0);
      chk("rst_gnt", 32'(gnt_4), 32'd0);
      chk("rst_ready", 32'({s0_ready_4, s1_ready_4}), 32'd0);
      chk("rst_state", 32'(state_4), 32'd0);
      chk("rst_prio", 32'(prio_4), 32'd0);

      // single beat from s0: grant at N+1, data at N+2, drain at N+3
      cyc();
      s0_valid = 1'b1;
      s0_data  = 8'hA1;
      m_ready  = 1'b1;
      @(negedge clk);
      chk("t1_gnt_n", 32'(gnt_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t1_gnt_n1", 32'(gnt_4), 32'b01);
      chk("t1_s0_ready_n1", 32'(s0_ready_4), 32'd1);
      chk("t1_s1_ready_n1", 32'(s1_ready_4), 32'd0);
      chk("t1_m_valid_n1", 32'(m_valid_4), 32'd0);
      cyc();
      s0_valid = 1'b0;
      @(negedge clk);
      chk("t1_m_valid_n2", 32'(m_valid_4), 32'd1);
      chk("t1_m_data_n2", 32'(m_data_4), 32'hA1);
      chk("t1_m_src_n2", 32'(m_src_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t1_m_valid_n3", 32'(m_valid_4), 32'd0);
      chk("t1_gnt_n3", 32'(gnt_4), 32'd0);
      chk("t1_prio_n3", 32'(prio_4), 32'd1);

      // both valid, streaming: bursts of 4 (dut4) and alternation (dut1)
      do_reset();
      drive_both(8'hA0, 8'hB0);
      cyc();
      cyc();
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back((i < 4 || i >= 8) ? 32'd0 : 32'd1);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("t2_m_valid", 32'(m_valid_4), 32'd1);
         chk("t2_m_src", 32'(m_src_4), e);
         chk("t2_m_data", 32'(m_data_4), (e == 32'd1) ? 32'hB0 : 32'hA0);
         chk("t5_m_valid", 32'(m_valid_1), 32'd1);
         chk("t5_m_src", 32'(m_src_1), 32'(i % 2));
         cyc();
      end
      // reset in the middle of an s1 burst
      @(negedge clk);
      chk("t6_pre_gnt", 32'(gnt_4), 32'b10);
      chk("t6_pre_prio", 32'(prio_4), 32'd1);
      chk("t6_pre_m_valid", 32'(m_valid_4), 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_m_valid", 32'(m_valid_4), 32'd0);
      chk("t6_m_data", 32'(m_data_4), 32'h00);
      chk("t6_gnt", 32'(gnt_4), 32'd0);
      chk("t6_prio", 32'(prio_4), 32'd0);
      chk("t6_ready", 32'({s0_ready_4, s1_ready_4}), 32'd0);
      chk("t6_state", 32'(state_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t6_restart_gnt", 32'(gnt_4), 32'b01);
      chk("t6_restart_m_valid", 32'(m_valid_4), 32'd0);

      // backpressure for 5 cycles after two beats of an s0 burst
      do_reset();
      drive_both(8'hA0, 8'hB0);
      cyc();
      cyc();
      cyc();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_stall_m_valid", 32'(m_valid_4), 32'd1);
         chk("t3_stall_m_data", 32'(m_data_4), 32'hA0);
         chk("t3_stall_ready", 32'({s0_ready_4, s1_ready_4}), 32'd0);
         chk("t3_stall_gnt", 32'(gnt_4), 32'b01);
         if (i < 4) cyc();
      end
      cyc();
      m_ready = 1'b1;
      @(negedge clk);
      chk("t3_resume_s0_ready", 32'(s0_ready_4), 32'd1);
      chk("t3_resume_gnt", 32'(gnt_4), 32'b01);
      cyc();
      @(negedge clk);
      chk("t3_beat4_gnt", 32'(gnt_4), 32'b01);
      chk("t3_beat3_src", 32'(m_src_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t3_handover_gnt", 32'(gnt_4), 32'b10);
      chk("t3_beat4_src", 32'(m_src_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t3_s1_src", 32'(m_src_4), 32'd1);
      chk("t3_s1_data", 32'(m_data_4), 32'hB0);

      // s0 drops valid after two beats while s1 waits
      do_reset();
      drive_both(8'hA0, 8'hB0);
      cyc();
      cyc();
      cyc();
      s0_valid = 1'b0;
      @(negedge clk);
      chk("t4_drop_gnt", 32'(gnt_4), 32'b01);
      chk("t4_drop_m_src", 32'(m_src_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t4_after_gnt", 32'(gnt_4), 32'b10);
      chk("t4_after_prio", 32'(prio_4), 32'd1);
      chk("t4_after_m_valid", 32'(m_valid_4), 32'd0);
      cyc();
      @(negedge clk);
      chk("t4_s1_m_valid", 32'(m_valid_4), 32'd1);
      chk("t4_s1_m_src", 32'(m_src_4), 32'd1);
      chk("t4_s1_m_data", 32'(m_data_4), 32'hB0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
